lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store sequencer between the execute/memory pipeline stage and the single-port data-memory bus. It accepts one memory operation at a time, stalls the pipeline while the bus transaction is in flight, and generates the word-aligned address, byte enables and lane-replicated store data. On loads it extracts and sign- or zero-extends the addressed byte or halfword. Misaligned accesses and bus timeouts are detected here and reported, with no silent corruption.

## Interface
- XLEN, 32, datapath width; only 32 is supported (4 byte lanes).
- TIMEOUT, 16, maximum cycles `o_memReq` is held without `i_memAck` before the access is aborted (range 1..255).
- i_clk  in  1  clock; all state changes on rising edge.
- i_rstn  in  1  reset, synchronous, active-low.
- i_start  in  1  operation request from the pipeline; sampled only in IDLE.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32 width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 treated as W.
- i_addr  in  XLEN  byte address.
- i_wdata  in  XLEN  store data, right-justified.
- o_stall  out  1  pipeline hold.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  XLEN  extended load result; valid while `o_done`=1.
- o_misaligned  out  1  with `o_done`: access was misaligned, no bus cycle issued.
- o_busErr  out  1  with `o_done`: access aborted by timeout.
- o_memReq  out  1  bus request.
- o_memWe  out  1  bus write.
- o_memAddr  out  XLEN  word address ({i_addr[31:2],2'b00}).
- o_memByteEn  out  4  byte-lane enables (stores; 4'b1111 on loads).
- o_memWdata  out  XLEN  lane-replicated store data.
- i_memAck  in  1  bus acknowledge; for loads, `i_memRdata` is valid in the same cycle.
- i_memRdata  in  XLEN  bus read data.

## Operation
- States: IDLE, BUS, DONE.
- IDLE, `i_start`=1, aligned: latch we/funct3/addr/wdata, clear timeout counter, go to BUS.
- IDLE, `i_start`=1, misaligned: go to DONE with misaligned flag set. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0. B is never misaligned.
- BUS: `o_memReq`=1. Bus outputs are driven from the latched operation and stay stable until ack.
  - `i_memAck`=1: capture the extended read data (loads) and go to DONE.
  - Else, counter = TIMEOUT-1: go to DONE with busErr set.
  - Else: increment the counter.
- DONE: `o_done`=1 with the flags; next state is IDLE unconditionally. `i_start` is ignored in DONE.
- Store lanes:
  - B: byteEn = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - H: byteEn = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - W: 4'b1111, wdata unchanged.
  - BU/HU stores behave as B/H.
- Load extract:
  - B/BU: byte at lane addr[1:0], sign- or zero-extended.
  - H/HU: halfword at addr[1], sign- or zero-extended.
  - W: full word.
- `o_rdata`=0 for stores, misaligned accesses and busErr.
- `i_memAck` outside BUS is ignored.

## Timing
- Reset (i_rstn=0 at an edge): state IDLE. `o_memReq`, `o_memWe`, `o_done`, `o_misaligned`, `o_busErr` = 0. `o_memAddr`, `o_memWdata`, `o_rdata` = 0. `o_memByteEn` = 0. Counter = 0.
- A reset mid-transaction drops `o_memReq` on the reset edge; no completion pulse is produced.
- `o_stall` (combinational) = (IDLE & i_start) | BUS. It is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Minimum aligned latency: start sampled at edge 0, `o_memReq` high in cycle 1, ack in cycle 1, `o_done` in cycle 2. That is 3 cycles per access.
- Misaligned latency: `o_done` in cycle 1; `o_memReq` never asserted.
- Timeout: `o_memReq` is high for exactly TIMEOUT cycles, then `o_done`+`o_busErr` in the next cycle.
- Ack arriving in the same cycle the counter expires counts as success (ack has priority).
- Back-to-back: the next `i_start` is accepted at the earliest in the cycle after DONE.

## Test plan
- LB, addr 0x1003, rdata 0x80FF_FF00, ack in the first BUS cycle -> memAddr 0x1000, byteEn 1111, `o_done` in cycle 2, o_rdata 0xFFFF_FF80.
- LHU, addr 0x2002, rdata 0xBEEF_1234 -> o_rdata 0x0000_BEEF. Same access as LH -> 0xFFFF_BEEF.
- SB, addr 0x3001, wdata 0x0000_00A5 -> byteEn 0010, memWdata 0xA5A5_A5A5, memWe 1. SH at 0x3002 -> byteEn 1100.
- LW, addr 0x4002 -> o_misaligned=1 with o_done in cycle 1, o_memReq never 1, o_rdata 0.
- TIMEOUT=4, no ack -> o_memReq high for 4 cycles, then o_done=1, o_busErr=1. Repeat with ack in the 4th cycle -> success, busErr 0.
- Reset asserted in the 2nd BUS cycle -> o_memReq 0 after that edge, no o_done pulse, and a fresh LW completes normally afterwards.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one memory operation at a time, with alignment checks, byte-lane steering,
// load extension and bus timeout.
module lsu_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_start,
  input  logic            i_we,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_misaligned,
  output logic            o_busErr,
  output logic            o_memReq,
  output logic            o_memWe,
  output logic [XLEN-1:0] o_memAddr,
  output logic [3:0]      o_memByteEn,
  output logic [XLEN-1:0] o_memWdata,
  input  logic            i_memAck,
  input  logic [XLEN-1:0] i_memRdata
);

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            mis_q, mis_d;
  logic            err_q, err_d;

  logic            start_mis;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wd;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [XLEN-1:0] ld_val;

  // Alignment check and store lane steering use the live request inputs.
  always_comb begin
    start_mis = 1'b0;
    st_be     = 4'b1111;
    st_wd     = i_wdata;
    unique case (i_funct3)
      3'b000, 3'b100: begin
        st_be = 4'b0001 << i_addr[1:0];
        st_wd = {4{i_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        start_mis = i_addr[0];
        st_be     = i_addr[1] ? 4'b1100 : 4'b0011;
        st_wd     = {2{i_wdata[15:0]}};
      end
      default: start_mis = (i_addr[1:0] != 2'b00);
    endcase
  end

  // Load extraction works from the latched operation and the live bus data.
  always_comb begin
    ld_b   = i_memRdata[{off_q, 3'b000} +: 8];
    ld_h   = off_q[1] ? i_memRdata[31:16] : i_memRdata[15:0];
    ld_val = i_memRdata;
    unique case (f3_q)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_val = {24'b0, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_val = {16'b0, ld_h};
      default: ld_val = i_memRdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          rdata_d = '0;
          err_d   = 1'b0;
          mis_d   = start_mis;
          if (start_mis) begin
            state_d = StDone;
          end else begin
            state_d = StBus;
            cnt_d   = '0;
            we_d    = i_we;
            f3_d    = i_funct3;
            off_d   = i_addr[1:0];
            addr_d  = {i_addr[XLEN-1:2], 2'b00};
            wdata_d = st_wd;
            be_d    = i_we ? st_be : 4'b1111;
          end
        end
      end
      StBus: begin
        // Ack wins over an expiring counter.
        if (i_memAck) begin
          rdata_d = we_q ? '0 : ld_val;
          state_d = StDone;
        end else if (cnt_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign o_stall      = ((state_q == StIdle) && i_start) || (state_q == StBus);
  assign o_done       = (state_q == StDone);
  assign o_rdata      = o_done ? rdata_q : '0;
  assign o_misaligned = o_done && mis_q;
  assign o_busErr     = o_done && err_q;
  assign o_memReq     = (state_q == StBus);
  assign o_memWe      = o_memReq && we_q;
  assign o_memAddr    = addr_q;
  assign o_memByteEn  = be_q;
  assign o_memWdata   = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: expected completions queued at issue, checked at o_done.
module tb_lsu_ctrl;
  localparam int unsigned Tmo = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall, done, mis, buserr, mreq, mwe;
  logic [31:0] rdata, maddr, mwdata;
  logic [3:0]  mbe;
  logic        mack = 1'b0;
  logic [31:0] mrdata = '0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        err;
  } exp_t;
  exp_t sb[$];

  lsu_ctrl #(.XLEN(32), .TIMEOUT(Tmo)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_we(we), .i_funct3(f3), .i_addr(addr),
    .i_wdata(wdata), .o_stall(stall), .o_done(done), .o_rdata(rdata), .o_misaligned(mis),
    .o_busErr(buserr), .o_memReq(mreq), .o_memWe(mwe), .o_memAddr(maddr), .o_memByteEn(mbe),
    .o_memWdata(mwdata), .i_memAck(mack), .i_memRdata(mrdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({mreq, mwe, done, mis, buserr, stall} !== 6'b0 || maddr !== 32'h0 ||
        mwdata !== 32'h0 || rdata !== 32'h0 || mbe !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_state: req=%b we=%b done=%b addr=%h wd=%h rd=%h be=%b want all 0",
               mreq, mwe, done, maddr, mwdata, rdata, mbe);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // ack_cyc = BUS cycle number (1-based) carrying the ack; 0 means never ack.
  task automatic run_op(input logic op_we, input logic [2:0] op_f3, input logic [31:0] op_addr,
                        input logic [31:0] op_wd, input int ack_cyc, input logic [31:0] bus_rd,
                        input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd,
                        input logic emis, input logic eerr, input logic poke_done);
    exp_t e, got;
    int done_at, reqs, exp_done;
    logic [31:0] emaddr;
    emaddr = {op_addr[31:2], 2'b00};
    e.rd = erd; e.mis = emis; e.err = eerr;
    sb.push_back(e);
    exp_done = emis ? 1 : ((ack_cyc == 0) ? Tmo + 1 : ack_cyc + 1);
    @(negedge clk);
    start = 1'b1; we = op_we; f3 = op_f3; addr = op_addr; wdata = op_wd;
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_on_start: got %b want 1", stall);
    end
    @(negedge clk);
    start = 1'b0;
    done_at = 0;
    reqs = 0;
    for (int c = 1; c <= 30 && done_at == 0; c++) begin
      if (mreq) begin
        reqs++;
        vectors++;
        if (maddr !== emaddr || mbe !== ebe || mwe !== op_we || (op_we && mwdata !== ewd) ||
            stall !== 1'b1) begin
          miscompares++;
          $display("FAIL bus_out: addr=%h be=%b we=%b wd=%h stall=%b want %h %b %b %h 1",
                   maddr, mbe, mwe, mwdata, stall, emaddr, ebe, op_we, ewd);
        end
      end
      if (done) begin
        done_at = c;
        got.rd = rdata; got.mis = mis; got.err = buserr;
        e = sb.pop_front();
        vectors++;
        if (got.rd !== e.rd || got.mis !== e.mis || got.err !== e.err || stall !== 1'b0 ||
            mreq !== 1'b0) begin
          miscompares++;
          $display("FAIL completion: rd=%h mis=%b err=%b stall=%b req=%b want %h %b %b 0 0",
                   got.rd, got.mis, got.err, stall, mreq, e.rd, e.mis, e.err);
        end
        if (poke_done) start = 1'b1;
      end else begin
        mack = (c == ack_cyc);
        mrdata = bus_rd;
        @(negedge clk);
      end
    end
    mack = 1'b0;
    if (done_at == 0) void'(sb.pop_front());
    vectors++;
    if (done_at != exp_done || reqs != (emis ? 0 : exp_done - 1)) begin
      miscompares++;
      $display("FAIL latency: done cycle %0d req cycles %0d want %0d %0d",
               done_at, reqs, exp_done, emis ? 0 : exp_done - 1);
    end
    if (poke_done) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      vectors++;
      if (mreq !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
        miscompares++;
        $display("FAIL start_in_done: req=%b done=%b stall=%b want 0 0 0", mreq, done, stall);
      end
    end
  endtask

  task automatic test_loads();
    run_op(0, 3'b000, 32'h1003, 0, 1, 32'h80FF_FF00, 4'hF, 0, 32'hFFFF_FF80, 0, 0, 0);
    run_op(0, 3'b101, 32'h2002, 0, 1, 32'hBEEF_1234, 4'hF, 0, 32'h0000_BEEF, 0, 0, 0);
    run_op(0, 3'b001, 32'h2002, 0, 2, 32'hBEEF_1234, 4'hF, 0, 32'hFFFF_BEEF, 0, 0, 0);
    run_op(0, 3'b100, 32'h6001, 0, 1, 32'h1234_8056, 4'hF, 0, 32'h0000_0080, 0, 0, 0);
    run_op(0, 3'b001, 32'h2000, 0, 3, 32'h0000_7FFF, 4'hF, 0, 32'h0000_7FFF, 0, 0, 0);
    run_op(0, 3'b011, 32'h4000, 0, 1, 32'h89AB_CDEF, 4'hF, 0, 32'h89AB_CDEF, 0, 0, 0);
  endtask

  task automatic test_stores();
    run_op(1, 3'b000, 32'h3001, 32'h0000_00A5, 1, 32'hFFFF_FFFF, 4'b0010, 32'hA5A5_A5A5, 0, 0, 0, 0);
    run_op(1, 3'b001, 32'h3002, 32'h1234_5678, 2, 32'hFFFF_FFFF, 4'b1100, 32'h5678_5678, 0, 0, 0, 0);
    run_op(1, 3'b010, 32'h5000, 32'hDEAD_BEEF, 3, 0, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0, 0);
    run_op(1, 3'b100, 32'h3003, 32'h7766_555A, 1, 0, 4'b1000, 32'h5A5A_5A5A, 0, 0, 0, 0);
    run_op(1, 3'b101, 32'h3000, 32'hFFFF_C3D2, 1, 0, 4'b0011, 32'hC3D2_C3D2, 0, 0, 0, 0);
  endtask

  task automatic test_misaligned();
    run_op(0, 3'b010, 32'h4002, 0, 1, 32'h1111_1111, 4'hF, 0, 0, 1, 0, 0);
    run_op(1, 3'b001, 32'h7001, 32'hABCD, 1, 0, 4'hF, 0, 0, 1, 0, 0);
    run_op(0, 3'b101, 32'h7003, 0, 1, 0, 4'hF, 0, 0, 1, 0, 0);
  endtask

  task automatic test_timeout();
    run_op(0, 3'b010, 32'h9000, 0, 0, 32'h5555_5555, 4'hF, 0, 0, 0, 1, 0);
    run_op(0, 3'b010, 32'h9004, 0, Tmo, 32'h5555_5555, 4'hF, 0, 32'h5555_5555, 0, 0, 0);
    run_op(1, 3'b000, 32'h9008, 32'h77, 0, 0, 4'b0001, 32'h7777_7777, 0, 0, 1, 0);
  endtask

  task automatic test_start_in_done();
    run_op(0, 3'b010, 32'hA000, 0, 1, 32'h0BAD_F00D, 4'hF, 0, 32'h0BAD_F00D, 0, 0, 1);
  endtask

  task automatic test_ack_idle();
    @(negedge clk);
    mack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || mreq !== 1'b0) begin
        miscompares++;
        $display("FAIL ack_in_idle: done=%b req=%b want 0 0", done, mreq);
      end
    end
    mack = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h8000;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (mreq !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_req_c1: got %b want 1", mreq);
    end
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    vectors++;
    if (mreq !== 1'b0 || done !== 1'b0 || maddr !== 32'h0 || mbe !== 4'h0) begin
      miscompares++;
      $display("FAIL mid_reset: req=%b done=%b addr=%h be=%b want 0 0 0 0", mreq, done, maddr, mbe);
    end
    rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || mreq !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_quiet: done=%b req=%b want 0 0", done, mreq);
      end
    end
    run_op(0, 3'b010, 32'h8004, 0, 2, 32'hCAFE_F00D, 4'hF, 0, 32'hCAFE_F00D, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_start_in_done();
    test_ack_idle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
